// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin arbiter sharing one single-port memory_top
// between the CPU bus (port 0) and the DMA/loader (port 1). One transaction
// is in flight at a time; new grants are held off while memory_top is busy.
//
// Requester handshake: a port raises reqN with weN/addrN/wdataN stable and
// keeps them stable until it sees the one-cycle ackN. gntN is high from the
// cycle after the grant decision through the ack cycle. A reqN still high in
// the IDLE cycle after ackN is treated as a fresh request.
module memory_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    // port 0: CPU bus
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    // port 1: DMA / loader
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    // memory_top side
    output logic                  mem_rd_enable,
    output logic                  mem_wr_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    // FSM state for observation
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    // ptr = 0 favours port 0 when both request, ptr = 1 favours port 1
    logic                  ptr;
    // port that owns the in-flight transaction
    logic                  winner;

    // latched copy of the winning request
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  grant_now;
    logic                  grant_port;

    // Grant decision: only in IDLE with memory_top free; contention resolved by ptr
    always_comb begin
        grant_now  = 1'b0;
        grant_port = 1'b0;
        if (state == IDLE && !mem_busy && (req0 || req1)) begin
            grant_now = 1'b1;
            if (req0 && req1) begin
                grant_port = ptr;
            end else begin
                grant_port = req1;
            end
        end
    end

    // Next-state logic: a write skips CAPTURE, a read waits one cycle for rd_data
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_now) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register and round-robin pointer; pointer flips away from the winner on completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DONE) begin
                ptr <= ~winner;
            end
        end
    end

    // Latch the winning request so requesters' inputs are not needed after the grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            winner  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_now) begin
            winner <= grant_port;
            if (grant_port) begin
                we_q    <= we1;
                addr_q  <= addr1;
                wdata_q <= wdata1;
            end else begin
                we_q    <= we0;
                addr_q  <= addr0;
                wdata_q <= wdata0;
            end
        end
    end

    // Read capture: only the winning port's rdata changes, and only on its own reads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == CAPTURE) begin
            if (winner) begin
                rdata1 <= mem_rd_data;
            end else begin
                rdata0 <= mem_rd_data;
            end
        end
    end

    // Port and memory outputs decoded from state; address/data hold the latch between transactions
    always_comb begin
        gnt0          = (state != IDLE) && !winner;
        gnt1          = (state != IDLE) &&  winner;
        ack0          = (state == DONE) && !winner;
        ack1          = (state == DONE) &&  winner;
        mem_wr_enable = (state == ISSUE) &&  we_q;
        mem_rd_enable = (state == ISSUE) && !we_q;
        mem_addr      = addr_q;
        mem_wr_data   = wdata_q;
        dbg_state     = state;
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed bench for memory_arbiter with a behavioural
// memory_top, a scoreboard of expected acks/read data, and latency checks.
module tb_memory_arbiter;

  localparam int DW = 8;
  localparam int AW = 12;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_rd_enable, mem_wr_enable;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_busy = 1'b1;
  logic [DW-1:0] mem_rd_data = '0;
  logic [1:0]    dbg_state;

  memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1),
    .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_busy(mem_busy), .mem_rd_data(mem_rd_data),
    .dbg_state(dbg_state)
  );

  // behavioural memory_top: rd_data valid the cycle after rd_enable
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wr_enable) mem[mem_addr] <= mem_wr_data;
    if (mem_rd_enable) mem_rd_data <= mem[mem_addr];
  end

  // ---------------- scoreboard ----------------
  // entry = {port, check_rdata, expected_rdata}
  logic [DW+1:0] exp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({gnt0, gnt1, ack0, ack1, mem_rd_enable, mem_wr_enable,
                mem_addr, mem_wr_data, rdata0, rdata1});
  endfunction

  // monitor: every ack must match the head of the queue; never two acks or two grants
  always @(negedge clk) begin : mon
    logic [DW+1:0] e;
    if (reset) begin
      chk("one_hot", 64'({ack0 & ack1, gnt0 & gnt1}), 64'(0));
      if (ack0 || ack1) begin
        chk("sb_has_entry", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("ack_port", 64'(ack1), 64'(e[DW+1]));
          if (e[DW]) chk("rdata", 64'(e[DW+1] ? rdata1 : rdata0), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic push_exp(input int p, input logic w, input logic [DW-1:0] rd);
    exp_q.push_back({p[0], ~w, (w ? 8'h00 : rd)});
  endtask

  // one isolated transaction starting in an IDLE cycle t, with latency checks
  task automatic txn(input int p, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
    tick();                                   // cycle t
    set_req(p, 1'b1, w, a, d);
    push_exp(p, w, exp_rd);
    tick();                                   // t+1
    chk("issue_en", 64'({mem_wr_enable, mem_rd_enable}), 64'(w ? 2'b10 : 2'b01));
    chk("issue_addr", 64'(mem_addr), 64'(a));
    if (w) chk("issue_wdata", 64'(mem_wr_data), 64'(d));
    chk("issue_gnt", 64'({gnt0, gnt1}), 64'(p == 0 ? 2'b10 : 2'b01));
    if (!w) begin
      tick();                                 // t+2 (capture)
      chk("capture_noack", 64'({ack0, ack1, mem_rd_enable}), 64'(0));
    end
    tick();                                   // ack cycle
    chk("ack_time", 64'({ack0, ack1}), 64'(p == 0 ? 2'b10 : 2'b01));
    chk("ack_en_low", 64'({mem_wr_enable, mem_rd_enable}), 64'(0));
    set_req(p, 1'b0, w, a, d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    logic [3:0] order;
    int n_ack;
    logic seen1;
    order = '0;

    // reset with memory busy (BIST) and port 0 already requesting a write
    set_req(0, 1'b1, 1'b1, 12'h010, 8'hA5);
    tick(); tick();
    chk("reset_outputs", out_vec(), 64'(0));
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("busy_hold", 64'({gnt0, gnt1, mem_wr_enable, mem_rd_enable}), 64'(0));
    end
    mem_busy = 1'b0;                          // this cycle is t
    push_exp(0, 1'b1, 8'h00);
    tick();
    chk("w0_issue", 64'({mem_wr_enable, mem_rd_enable, gnt0, mem_addr, mem_wr_data}),
        64'({1'b1, 1'b0, 1'b1, 12'h010, 8'hA5}));
    tick();
    chk("w0_ack", 64'({ack0, ack1, mem_wr_enable}), 64'(3'b100));
    set_req(0, 1'b0, 1'b1, 12'h010, 8'hA5);
    tick();
    chk("w0_gnt_drop", 64'({gnt0, gnt1, ack0}), 64'(0));
    chk("addr_hold", 64'({mem_addr, mem_wr_data}), 64'({12'h010, 8'hA5}));

    // port 0 reads back
    txn(0, 1'b0, 12'h010, 8'h00, 8'hA5);

    // reset pulse, then both ports stream writes: grants alternate 0,1,0,1
    tick();
    reset = 1'b0;
    #1 chk("reset2_outputs", out_vec(), 64'(0));
    tick();
    reset = 1'b1;
    tick();
    set_req(0, 1'b1, 1'b1, 12'h100, 8'h11);
    set_req(1, 1'b1, 1'b1, 12'h200, 8'h22);
    push_exp(0, 1'b1, 8'h00); push_exp(1, 1'b1, 8'h00);
    push_exp(0, 1'b1, 8'h00); push_exp(1, 1'b1, 8'h00);
    n_ack = 0;
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      tick();
      if (ack0 || ack1) begin
        order[n_ack] = ack1;
        n_ack++;
        if (n_ack == 4) begin
          set_req(0, 1'b0, 1'b1, 12'h100, 8'h11);
          set_req(1, 1'b0, 1'b1, 12'h200, 8'h22);
        end
      end
    end
    chk("alt_count", 64'(n_ack), 64'(4));
    chk("alt_order", 64'(order), 64'(4'b1010));

    // port 0 read restores rdata0; port 1 write/read at top address
    txn(0, 1'b0, 12'h010, 8'h00, 8'hA5);
    txn(1, 1'b1, 12'hFFF, 8'h3C, 8'h00);
    txn(1, 1'b0, 12'hFFF, 8'h00, 8'h3C);
    chk("rdata0_kept", 64'(rdata0), 64'(8'hA5));
    chk("rdata1_val", 64'(rdata1), 64'(8'h3C));

    // reset during CAPTURE of a port 1 read: outputs clear at once, no ack
    tick();
    set_req(1, 1'b1, 1'b0, 12'hFFF, 8'h00);
    push_exp(1, 1'b0, 8'h3C);
    tick();                                   // ISSUE
    chk("rst_rd_issue", 64'(mem_rd_enable), 64'(1));
    tick();                                   // CAPTURE
    reset = 1'b0;
    set_req(1, 1'b0, 1'b0, 12'hFFF, 8'h00);
    #1 chk("rst_capture_outputs", out_vec(), 64'(0));
    void'(exp_q.pop_back());                  // transaction dropped
    tick();
    chk("rst_no_ack", 64'({ack0, ack1}), 64'(0));
    reset = 1'b1;
    tick();
    set_req(0, 1'b1, 1'b1, 12'h040, 8'hC1);
    set_req(1, 1'b1, 1'b1, 12'h050, 8'hD2);
    push_exp(0, 1'b1, 8'h00); push_exp(1, 1'b1, 8'h00);
    tick();
    chk("ptr_after_reset", 64'({gnt0, gnt1}), 64'(2'b10));
    seen1 = 1'b0;
    for (int i = 0; i < 20 && !seen1; i++) begin
      tick();
      if (ack1) begin
        seen1 = 1'b1;
        set_req(0, 1'b0, 1'b1, 12'h040, 8'hC1);
        set_req(1, 1'b0, 1'b1, 12'h050, 8'hD2);
      end
    end
    chk("ptr_seq_done", 64'(seen1), 64'(1));

    // mem_busy rising during ISSUE is ignored; the next request then waits
    tick();
    set_req(0, 1'b1, 1'b1, 12'h020, 8'h5A);
    push_exp(0, 1'b1, 8'h00);
    tick();
    chk("busy_issue_en", 64'(mem_wr_enable), 64'(1));
    mem_busy = 1'b1;
    tick();
    chk("busy_ack", 64'({ack0, ack1}), 64'(2'b10));
    set_req(0, 1'b0, 1'b1, 12'h020, 8'h5A);
    set_req(1, 1'b1, 1'b1, 12'h030, 8'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_wait", 64'({gnt1, mem_wr_enable, mem_rd_enable}), 64'(0));
    end
    mem_busy = 1'b0;                          // cycle t
    push_exp(1, 1'b1, 8'h00);
    tick();
    chk("busy_rel_issue", 64'({mem_wr_enable, gnt1, mem_addr}), 64'({2'b11, 12'h030}));
    tick();
    chk("busy_rel_ack", 64'({ack0, ack1}), 64'(2'b01));
    set_req(1, 1'b0, 1'b1, 12'h030, 8'h77);
    tick(); tick();
    chk("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
